// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data memory responder for the MEM pipeline stage
module data_mem_responder #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 64,
    parameter int LATENCY  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN,
    input  logic                MEM_W_EN,
    input  logic [WORD_LEN-1:0] addr,
    input  logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] rdata,
    output logic                rsp_valid,
    output logic                stall,
    output logic                err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic [WORD_LEN-1:0]   addr_q;
    logic [WORD_LEN-1:0]   wdata_q;
    logic                  load_q;
    logic                  accept;
    logic                  execute;
    logic                  illegal_q;
    logic [AW-1:0]         index_q;
    logic [WORD_LEN-1:0]   mem [DEPTH];

    assign illegal_q = (addr_q[1:0] != 2'b00) || (addr_q >= WORD_LEN'(4 * DEPTH));
    assign index_q   = addr_q[AW+1:2];
    assign execute   = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        err       = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_R_EN && MEM_W_EN) begin
                    err = 1'b1;
                end else if (MEM_R_EN || MEM_W_EN) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                err       = illegal_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are forced quiet while reset is held, regardless of inputs.
        if (!rst) begin
            accept = 1'b0;
            stall  = 1'b0;
            err    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                load_q  <= MEM_R_EN;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (execute && load_q) begin
                rdata <= illegal_q ? '0 : mem[index_q];
            end
        end
    end

    // Storage is deliberately outside the reset domain; reset only aborts in-flight writes.
    always_ff @(posedge clk) begin
        if (execute && !load_q && !illegal_q) begin
            mem[index_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and random scoreboard bench for data_mem_responder
module tb_data_mem_responder;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rsp_valid;
    logic        stall;
    logic        err;

    data_mem_responder #(.WORD_LEN(32), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rsp_valid(rsp_valid),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) chk("stall_rsp_exclusive", {31'b0, stall & rsp_valid}, 32'd0);
    end

    // Called on a falling edge; returns on a falling edge with requests idle.
    task automatic access(input logic ld, input logic [31:0] a, input logic [31:0] d,
                          input bit scramble);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   ill;
        ill   = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        e.err = ill;
        if (ld) begin
            e.rdata = ill ? 32'd0 : model[a[7:2]];
        end else begin
            e.rdata = last_rdata;
            if (!ill) model[a[7:2]] = d;
        end
        last_rdata = e.rdata;
        sb.push_back(e);

        MEM_R_EN = ld;
        MEM_W_EN = !ld;
        addr     = a;
        wdata    = d;
        #1;
        chk("accept_stall", {31'b0, stall}, 32'd1);
        chk("accept_err", {31'b0, err}, 32'd0);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (scramble) begin
                addr  = 32'h0;
                wdata = 32'h0;
            end
            if (rsp_valid === 1'b1) break;
            if (cyc > 20) begin
                chk("rsp_timeout", 32'd1, 32'd0);
                break;
            end
            chk("busy_stall", {31'b0, stall}, 32'd1);
        end
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        chk("rsp_latency", 32'(cyc), 32'(LATENCY + 1));
        chk("resp_stall", {31'b0, stall}, 32'd0);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("resp_rdata", rdata, got.rdata);
            chk("resp_err", {31'b0, err}, {31'b0, got.err});
        end
        @(negedge clk);
        chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_err", {31'b0, err}, 32'd0);
    endtask

    initial begin
        last_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) access(1'b0, 32'(i * 4), $urandom, 1'b0);

        access(1'b0, 32'h8, 32'hDEADBEEF, 1'b0);
        access(1'b1, 32'h8, 32'h0, 1'b0);

        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b1;
        addr     = 32'h8;
        wdata    = 32'h12345678;
        #1;
        chk("both_err", {31'b0, err}, 32'd1);
        chk("both_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        #1;
        chk("both_no_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("both_idle_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        access(1'b1, 32'h8, 32'h0, 1'b0);

        access(1'b1, 32'h6, 32'h0, 1'b0);
        access(1'b0, 32'h100, 32'hA5A5A5A5, 1'b0);
        access(1'b1, 32'h0, 32'h0, 1'b0);
        access(1'b1, 32'hFC, 32'h0, 1'b0);

        access(1'b0, 32'h10, 32'hCAFEF00D, 1'b1);
        access(1'b1, 32'h10, 32'h0, 1'b0);
        access(1'b1, 32'h0, 32'h0, 1'b0);

        // Store to 0xC aborted by reset in its second BUSY cycle.
        MEM_W_EN = 1'b1;
        addr     = 32'hC;
        wdata    = 32'h0BADC0DE;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_err", {31'b0, err}, 32'd0);
        MEM_W_EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_rdata = 32'd0;
        access(1'b1, 32'hC, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int          kind;
            kind = $urandom_range(0, 7);
            a    = 32'($urandom_range(0, DEPTH - 1) * 4);
            if (kind == 0) a = a | 32'($urandom_range(1, 3));
            if (kind == 1) a = a + 32'(4 * DEPTH);
            access(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
